// File: rtl/ibufgds_pkg.sv
// Shared definitions for the differential input buffer: legal attribute
// strings, default counter width and the elaboration-time parameter check.
`timescale 1ns/1ps
package ibufgds_pkg;

  localparam string ATTR_TRUE  = "TRUE";
  localparam string ATTR_FALSE = "FALSE";

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int CNT_WIDTH_MIN     = 4;
  localparam int CNT_WIDTH_MAX     = 32;

  function automatic bit attr_bool_ok(input string value);
    return (value == ATTR_TRUE) || (value == ATTR_FALSE);
  endfunction

  // IOSTANDARD is free-form and only has to be non-empty.
  function automatic bit params_ok(input string diff_term,
                                   input string ibuf_low_pwr,
                                   input string iostandard,
                                   input int    cnt_width);
    return attr_bool_ok(diff_term) && attr_bool_ok(ibuf_low_pwr) &&
           (iostandard != "") &&
           (cnt_width >= CNT_WIDTH_MIN) && (cnt_width <= CNT_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/ibufgds_monitor.sv
// Bring-up monitor for the differential pair: counts and flags samples where
// the legs are not complementary, sampled on clock127.
`timescale 1ns/1ps
module ibufgds_monitor
  import ibufgds_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clock127,
  input  logic                 reset,
  input  logic                 i,
  input  logic                 ib,
  output logic [CNT_WIDTH-1:0] invalid_count,
  output logic                 invalid_sticky,
  output logic                 diff_ok
);

  // Anything other than a clean 1 from the XOR (equal legs, X or Z) is invalid.
  logic sample_invalid;
  assign sample_invalid = ((i ^ ib) !== 1'b1);

  always_ff @(posedge clock127) begin
    if (reset) begin
      invalid_count  <= '0;
      invalid_sticky <= 1'b0;
      diff_ok        <= 1'b0;
    end else begin
      if (sample_invalid) begin
        invalid_sticky <= 1'b1;
        if (invalid_count != '1)
          invalid_count <= invalid_count + 1'b1;
      end
      diff_ok <= !sample_invalid;
    end
  end

endmodule

// File: rtl/ibufgds.sv
// LVDS input buffer: zero-delay differential-to-single-ended conversion that
// holds the last valid level, plus the clock127 invalid-sample monitor.
`timescale 1ns/1ps
module ibufgds
  import ibufgds_pkg::*;
#(
  parameter string DIFF_TERM    = "FALSE",
  parameter string IBUF_LOW_PWR = "TRUE",
  parameter string IOSTANDARD   = "DEFAULT",
  parameter int    CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
  input  logic                 clock127,
  input  logic                 reset,
  input  logic                 I,
  input  logic                 IB,
  output logic                 O,
  output logic [CNT_WIDTH-1:0] invalid_count,
  output logic                 invalid_sticky,
  output logic                 diff_ok
);

  if (!params_ok(DIFF_TERM, IBUF_LOW_PWR, IOSTANDARD, CNT_WIDTH)) begin : g_bad_params
    $fatal(1, "ibufgds: illegal DIFF_TERM/IBUF_LOW_PWR/IOSTANDARD/CNT_WIDTH value");
  end

  // Transparent only while the pair is cleanly complementary, so O follows I
  // with no clock and never picks up an X or an equal-legs level.
  logic o_hold;
  always_latch begin
    if ((I ^ IB) === 1'b1)
      o_hold <= I;
  end
  assign O = o_hold;

  ibufgds_monitor #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_monitor (
    .clock127      (clock127),
    .reset         (reset),
    .i             (I),
    .ib            (IB),
    .invalid_count (invalid_count),
    .invalid_sticky(invalid_sticky),
    .diff_ok       (diff_ok)
  );

endmodule

// File: tb/tb_ibufgds.sv
// Self-checking bench for ibufgds: directed bring-up scenarios plus a random
// phase, all compared against a sample-count model of the pair.
`timescale 1ns/1ps
module tb_ibufgds;

  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clock127 = 1'b0;
  logic         reset    = 1'b1;
  logic         I        = 1'b0;
  logic         IB       = 1'b1;
  logic         O;
  logic [W-1:0] invalid_count;
  logic         invalid_sticky;
  logic         diff_ok;

  ibufgds #(
    .DIFF_TERM   ("TRUE"),
    .IBUF_LOW_PWR("FALSE"),
    .IOSTANDARD  ("LVDS_25"),
    .CNT_WIDTH   (W)
  ) dut (
    .clock127      (clock127),
    .reset         (reset),
    .I             (I),
    .IB            (IB),
    .O             (O),
    .invalid_count (invalid_count),
    .invalid_sticky(invalid_sticky),
    .diff_ok       (diff_ok)
  );

  always #4 clock127 = ~clock127;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of invalid samples since reset, and whether the last
  // sample was complementary. Outputs derive from these by plain arithmetic.
  int   m_invalid_n  = 0;
  bit   m_last_ok    = 1'b0;
  bit   m_check_en   = 1'b0;
  logic exp_o        = 1'b0;
  int   o_edges      = 0;

  always @(posedge clock127) begin
    if (reset) begin
      m_invalid_n <= 0;
      m_last_ok   <= 1'b0;
    end else begin
      if (I == IB) m_invalid_n <= m_invalid_n + 1;
      m_last_ok <= (I != IB);
    end
    m_check_en <= 1'b1;
  end

  always @(O) o_edges <= o_edges + 1;

  function automatic int model_count();
    return (m_invalid_n > MAXC) ? MAXC : m_invalid_n;
  endfunction

  always @(negedge clock127) begin
    if (m_check_en) begin
      check("invalid_count", invalid_count, model_count());
      check("invalid_sticky", invalid_sticky, (m_invalid_n > 0) ? 1 : 0);
      check("diff_ok", diff_ok, m_last_ok ? 1 : 0);
    end
  end

  // Drive the pair and check O a tick later: it must already follow.
  task automatic drive(input logic i_v, input logic ib_v);
    I  = i_v;
    IB = ib_v;
    if (i_v != ib_v) exp_o = i_v;
    #0.1;
    check("O_follow", O, exp_o);
  endtask

  initial begin
    int   edges0;
    logic o_before;
    int   r;

    #0.1;
    check("O_initial", O, 0);
    repeat (2) @(posedge clock127);
    #2 reset = 1'b0;

    // Static levels
    drive(1'b0, 1'b1);
    check("O_static0", O, 0);
    @(posedge clock127); #2;
    drive(1'b1, 1'b0);
    check("O_static1", O, 1);
    @(posedge clock127); #1;
    check("diff_ok_static", diff_ok, 1);

    // Clock pair toggling every 4 ns
    @(posedge clock127); #1;
    repeat (1000) begin
      drive(1'b0, 1'b1); #3.9;
      drive(1'b1, 1'b0); #3.9;
    end
    check("count_after_toggle", invalid_count, 0);
    check("sticky_after_toggle", invalid_sticky, 0);

    // Revolution pulses: exactly one rise and one fall per pulse
    drive(1'b0, 1'b1);
    edges0 = o_edges;
    repeat (3) begin
      #10232;
      drive(1'b1, 1'b0);
      #7.8;
      check("revo_pulse_high", O, 1);
      #0.1;
      drive(1'b0, 1'b1);
      check("revo_pulse_low", O, 0);
    end
    #0.1;
    check("revo_edges", o_edges - edges0, 6);

    // Invalid from O=1 for 3 cycles
    @(posedge clock127); #2;
    drive(1'b1, 1'b0);
    @(posedge clock127); #2;
    drive(1'b1, 1'b1);
    check("O_hold_11", O, 1);
    repeat (3) @(posedge clock127);
    #1;
    check("count_after_3", invalid_count, 3);
    check("sticky_after_3", invalid_sticky, 1);
    check("diff_ok_after_3", diff_ok, 0);
    drive(1'b0, 1'b1);
    check("O_recover", O, 0);
    @(posedge clock127); #1;
    check("diff_ok_recover", diff_ok, 1);
    check("sticky_stays", invalid_sticky, 1);

    // Saturation: 3 + 20 invalid samples on a 4-bit counter
    #1;
    drive(1'b0, 1'b0);
    check("O_hold_00", O, 0);
    repeat (20) @(posedge clock127);
    #1;
    check("count_saturated", invalid_count, 15);

    // Clear, build up to 7, then a 1-cycle reset alongside an invalid sample
    #1 reset = 1'b1;
    drive(1'b1, 1'b0);
    @(posedge clock127); #2;
    reset = 1'b0;
    drive(1'b1, 1'b1);
    repeat (7) @(posedge clock127);
    #2;
    check("count_seven", invalid_count, 7);
    o_before = O;
    reset = 1'b1;
    @(posedge clock127); #1;
    check("reset_count", invalid_count, 0);
    check("reset_sticky", invalid_sticky, 0);
    check("reset_diff_ok", diff_ok, 0);
    check("reset_O_unchanged", O, o_before);
    check("reset_O_value", O, 1);
    #1 reset = 1'b0;
    @(posedge clock127); #1;
    check("count_restart", invalid_count, 1);

    // Random phase
    repeat (2000) begin
      @(posedge clock127); #2;
      r = $urandom_range(0, 99);
      reset = (r < 4);
      if ($urandom_range(0, 99) < 30) begin
        r = $urandom_range(0, 1);
        drive(r[0], r[0]);
      end else begin
        r = $urandom_range(0, 1);
        drive(r[0], ~r[0]);
      end
      if ($urandom_range(0, 3) == 0) begin
        #1;
        r = $urandom_range(0, 3);
        drive(r[1], r[0]);
      end
    end

    reset = 1'b0;
    @(posedge clock127);
    @(negedge clock127);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
